// File: rtl/jtag_shift_transmitter.sv
// JTAG data-register TDO serialiser: loads a WIDTH-bit word and shifts it out while shifting TDI in,
// all state on the falling edge of clk. Define JTAG_TX_PARITY_EN to append an odd-parity bit.
module jtag_shift_transmitter #(
    parameter int unsigned  WIDTH     = 32,
    parameter bit           LSB_FIRST = 1'b0,
`ifdef JTAG_TX_PARITY_EN
    localparam int unsigned TOTAL     = WIDTH + 1,
`else
    localparam int unsigned TOTAL     = WIDTH,
`endif
    localparam int unsigned CNT_W     = $clog2(TOTAL + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    input  logic             tdi,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic [CNT_W-1:0] bits_sent
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOADED,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   rx_q, rx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef JTAG_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    logic               tx_bit_c;
    logic [WIDTH-1:0]   sr_shift_c;

    // Outgoing bit leaves one end; tdi fills the vacated position at the other end.
    assign tx_bit_c   = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
    assign sr_shift_c = LSB_FIRST ? {tdi, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], tdi};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef JTAG_TX_PARITY_EN
        par_d   = par_q;
`endif
        // A load restarts the word from any state except the one-cycle DONE pulse.
        if (load && (state_q != ST_DONE)) begin
            sr_d    = data_in;
            cnt_d   = '0;
            out_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_LOADED;
`ifdef JTAG_TX_PARITY_EN
            par_d   = ~^data_in;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_d = 1'b0;
                end
                ST_LOADED: begin
                    if (shift_en) begin
                        out_d   = tx_bit_c;
                        sr_d    = sr_shift_c;
                        cnt_d   = CNT_W'(1);
                        busy_d  = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (shift_en) begin
                        if (cnt_q == CNT_W'(TOTAL)) begin
                            out_d   = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            rx_d    = sr_q;
                            state_d = ST_DONE;
`ifdef JTAG_TX_PARITY_EN
                        end else if (cnt_q == CNT_W'(WIDTH)) begin
                            // Parity slot: the tdi bit of this cycle is dropped.
                            out_d = par_q;
                            cnt_d = cnt_q + CNT_W'(1);
`endif
                        end else begin
                            out_d = tx_bit_c;
                            sr_d  = sr_shift_c;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    out_d   = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Falling-edge update keeps TDO stable across the rising TCK sample point.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef JTAG_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef JTAG_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rx_data   = rx_q;
    assign bits_sent = cnt_q;

endmodule

// File: tb/tb_jtag_shift_transmitter.sv
// Bench for jtag_shift_transmitter: three instances (32 MSB-first, 8 MSB-first, 8 LSB-first) on shared
// stimulus, checked against a bit-indexed reference model plus directed corner sequences.
module tb_jtag_shift_transmitter;

`ifdef JTAG_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned T32  = 32 + PAR;
    localparam int unsigned T8   = 8 + PAR;
    localparam int unsigned CW32 = $clog2(T32 + 1);
    localparam int unsigned CW8  = $clog2(T8 + 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        shift_en = 1'b0;
    logic        tdi = 1'b0;
    logic [63:0] data_in = '0;

    logic            out32, busy32, done32;
    logic [31:0]     rx32;
    logic [CW32-1:0] cnt32;
    logic            out8m, busy8m, done8m;
    logic [7:0]      rx8m;
    logic [CW8-1:0]  cnt8m;
    logic            out8l, busy8l, done8l;
    logic [7:0]      rx8l;
    logic [CW8-1:0]  cnt8l;

    always #5 clk = ~clk;

    jtag_shift_transmitter #(.WIDTH(32), .LSB_FIRST(1'b0)) u32 (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in[31:0]), .shift_en(shift_en),
        .tdi(tdi), .out(out32), .busy(busy32), .done(done32), .rx_data(rx32), .bits_sent(cnt32));
    jtag_shift_transmitter #(.WIDTH(8), .LSB_FIRST(1'b0)) u8m (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in[7:0]), .shift_en(shift_en),
        .tdi(tdi), .out(out8m), .busy(busy8m), .done(done8m), .rx_data(rx8m), .bits_sent(cnt8m));
    jtag_shift_transmitter #(.WIDTH(8), .LSB_FIRST(1'b1)) u8l (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in[7:0]), .shift_en(shift_en),
        .tdi(tdi), .out(out8l), .busy(busy8l), .done(done8l), .rx_data(rx8l), .bits_sent(cnt8l));

    logic [2:0]  o_out, o_busy, o_done;
    logic [63:0] o_rx  [3];
    logic [7:0]  o_cnt [3];
    assign o_out  = {out8l, out8m, out32};
    assign o_busy = {busy8l, busy8m, busy32};
    assign o_done = {done8l, done8m, done32};
    assign o_rx[0] = 64'(rx32);
    assign o_rx[1] = 64'(rx8m);
    assign o_rx[2] = 64'(rx8l);
    assign o_cnt[0] = 8'(cnt32);
    assign o_cnt[1] = 8'(cnt8m);
    assign o_cnt[2] = 8'(cnt8l);

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: phase 0 idle, 1 loaded, 2 shifting, 3 done pulse.
    int          m_st   [3] = '{0, 0, 0};
    int unsigned m_k    [3] = '{0, 0, 0};
    logic [63:0] m_word [3] = '{64'd0, 64'd0, 64'd0};
    logic [63:0] m_acc  [3] = '{64'd0, 64'd0, 64'd0};
    logic [63:0] m_rx   [3] = '{64'd0, 64'd0, 64'd0};
    logic        m_out  [3] = '{1'b0, 1'b0, 1'b0};
    logic        m_busy [3] = '{1'b0, 1'b0, 1'b0};
    logic        m_done [3] = '{1'b0, 1'b0, 1'b0};

    function automatic int unsigned wid(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic bit lsbf(input int i);
        return i == 2;
    endfunction

    // Bit number k of the transmitted frame; index WIDTH is the parity slot.
    function automatic logic txbit(input int i, input int unsigned k);
        int unsigned w;
        w = wid(i);
        if (k == w) return ~^m_word[i];
        return lsbf(i) ? m_word[i][k] : m_word[i][w - 1 - k];
    endfunction

    task automatic model_step(input logic r, input logic l, input logic [63:0] d,
                              input logic s, input logic t);
        for (int i = 0; i < 3; i++) begin
            int unsigned w;
            int unsigned pos;
            w = wid(i);
            m_done[i] = 1'b0;
            if (r) begin
                m_st[i] = 0; m_k[i] = 0; m_acc[i] = '0; m_rx[i] = '0;
                m_out[i] = 1'b0; m_busy[i] = 1'b0; m_word[i] = '0;
            end else if (l && m_st[i] != 3) begin
                m_word[i] = d & ((64'd1 << w) - 64'd1);
                m_k[i] = 0; m_acc[i] = '0; m_out[i] = 1'b0; m_busy[i] = 1'b0; m_st[i] = 1;
            end else begin
                case (m_st[i])
                    1: if (s) begin
                        m_out[i] = txbit(i, 0);
                        pos = lsbf(i) ? 0 : w - 1;
                        m_acc[i][pos] = t;
                        m_k[i] = 1; m_busy[i] = 1'b1; m_st[i] = 2;
                    end
                    2: if (s) begin
                        if (m_k[i] == w + PAR) begin
                            m_out[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b1;
                            m_rx[i] = m_acc[i]; m_st[i] = 3;
                        end else begin
                            m_out[i] = txbit(i, m_k[i]);
                            if (m_k[i] < w) begin
                                pos = lsbf(i) ? m_k[i] : w - 1 - m_k[i];
                                m_acc[i][pos] = t;
                            end
                            m_k[i] = m_k[i] + 1;
                        end
                    end
                    3: begin m_out[i] = 1'b0; m_st[i] = 0; end
                    default: m_out[i] = 1'b0;
                endcase
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_out_busy_done_cnt", i),
                64'({o_out[i], o_busy[i], o_done[i], o_cnt[i]}),
                64'({m_out[i], m_busy[i], m_done[i], 8'(m_k[i])}));
            chk($sformatf("d%0d_rx", i), o_rx[i], m_rx[i]);
        end
    endtask

    // Inputs change on the rising edge, the design acts on the falling edge, checks on the next rise.
    task automatic cycle(input logic r, input logic l, input logic [63:0] d,
                         input logic s, input logic t);
        reset = r; load = l; data_in = d; shift_en = s; tdi = t;
        @(negedge clk);
        model_step(r, l, d, s, t);
        @(posedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [63:0] d);
        cycle(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic sh(input logic t);
        cycle(1'b0, 1'b0, 64'd0, 1'b1, t);
    endtask

    typedef struct {
        logic        ld;
        logic [63:0] d;
        logic        se;
        logic        ti;
        logic        eo;
        logic        ed;
    } vec_t;

    function automatic vec_t mk(input logic l, input logic [63:0] d, input logic s,
                                input logic t, input logic eo, input logic ed);
        vec_t v;
        v.ld = l; v.d = d; v.se = s; v.ti = t; v.eo = eo; v.ed = ed;
        return v;
    endfunction

    vec_t        tv[$];
    logic [63:0] cap;
    logic [7:0]  tpat, opat;
    int          dcnt;
    logic        r_rst, r_ld, r_se, r_ti;
    logic [63:0] r_d;

    initial begin
        @(posedge clk);
        cycle(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'hFFFF_FFFF, 1'b1, 1'b1);
        chk("reset_out", 64'(o_out), 64'd0);
        chk("reset_busy_done", 64'({o_busy, o_done}), 64'd0);
        chk("reset_cnt32", 64'(o_cnt[0]), 64'd0);
        chk("reset_rx32", o_rx[0], 64'd0);

        // 32-bit MSB-first word with tdi held low.
        idle(1);
        ld(64'hA5A5_F00F);
        cap = '0; dcnt = 0;
        for (int j = 1; j <= 33 + PAR; j++) begin
            sh(1'b0);
            if (j <= 32) cap = {cap[62:0], o_out[0]};
            if (o_done[0]) dcnt++;
            if (j == 33 + PAR) chk("t1_done_at_end", 64'(o_done[0]), 64'd1);
        end
        chk("t1_out_seq", cap[31:0], 64'hA5A5_F00F);
        chk("t1_done_count", 64'(dcnt), 64'd1);
        chk("t1_rx", o_rx[0], 64'd0);

        // LSB-first 8-bit word with a tdi pattern, driven from a vector table.
        idle(2);
        tpat = 8'h53;
        opat = 8'h81;
        tv.push_back(mk(1'b1, 64'h81, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int j = 0; j < 8; j++) tv.push_back(mk(1'b0, 64'd0, 1'b1, tpat[j], opat[j], 1'b0));
        if (PAR != 0) tv.push_back(mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0));
        tv.push_back(mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        foreach (tv[j]) begin
            cycle(1'b0, tv[j].ld, tv[j].d, tv[j].se, tv[j].ti);
            chk($sformatf("t2_out[%0d]", j), 64'(o_out[2]), 64'(tv[j].eo));
            chk($sformatf("t2_done[%0d]", j), 64'(o_done[2]), 64'(tv[j].ed));
        end
        chk("t2_rx", o_rx[2], 64'h53);

        // Pause for five cycles after three bits, then resume.
        idle(2);
        ld(64'hF0);
        cap = '0; dcnt = 0;
        for (int j = 0; j < 3; j++) begin sh(1'b1); cap = {cap[62:0], o_out[1]}; end
        for (int j = 0; j < 5; j++) begin
            idle(1);
            chk("t3_pause_out", 64'(o_out[1]), 64'd1);
            chk("t3_pause_cnt", 64'(o_cnt[1]), 64'd3);
            chk("t3_pause_busy", 64'(o_busy[1]), 64'd1);
        end
        for (int j = 0; j < 5; j++) begin sh(1'b1); cap = {cap[62:0], o_out[1]}; end
        for (int j = 0; j < int'(PAR) + 3; j++) begin
            if (j <= int'(PAR)) sh(1'b0); else idle(1);
            if (o_done[1]) dcnt++;
        end
        chk("t3_out_seq", cap[7:0], 64'hF0);
        chk("t3_done_count", 64'(dcnt), 64'd1);
        chk("t3_rx", o_rx[1], 64'hFF);

        // Reset in the middle of a 32-bit shift, then a clean word.
        idle(2);
        ld(64'hDEAD_BEEF);
        for (int j = 0; j < 10; j++) sh(1'b1);
        cycle(1'b1, 1'b1, 64'h1234, 1'b1, 1'b1);
        chk("t4_rst_out", 64'(o_out[0]), 64'd0);
        chk("t4_rst_busy", 64'(o_busy[0]), 64'd0);
        chk("t4_rst_cnt", 64'(o_cnt[0]), 64'd0);
        chk("t4_rst_done", 64'(o_done[0]), 64'd0);
        ld(64'h1);
        cap = '0; dcnt = 0;
        for (int j = 1; j <= 33 + PAR; j++) begin
            sh(1'b1);
            if (j <= 32) cap = {cap[62:0], o_out[0]};
            if (o_done[0]) dcnt++;
        end
        chk("t4_out_seq", cap[31:0], 64'h1);
        chk("t4_done_count", 64'(dcnt), 64'd1);
        chk("t4_rx", o_rx[0], 64'hFFFF_FFFF);

        // Load and shift_en together mid-shift: load wins and restarts the word.
        idle(2);
        dcnt = 0;
        ld(64'h3C);
        for (int j = 0; j < 4; j++) begin sh(1'b0); if (o_done[1]) dcnt++; end
        cycle(1'b0, 1'b1, 64'hFF, 1'b1, 1'b1);
        chk("t5_restart_cnt", 64'(o_cnt[1]), 64'd0);
        chk("t5_restart_busy", 64'(o_busy[1]), 64'd0);
        chk("t5_abort_no_done", 64'(dcnt), 64'd0);
        cap = '0;
        for (int j = 0; j < 9 + int'(PAR); j++) begin
            sh(1'b0);
            if (j == 0) chk("t5_first_bit", 64'(o_out[1]), 64'd1);
            if (j < 8) cap = {cap[62:0], o_out[1]};
            if (o_done[1]) dcnt++;
        end
        chk("t5_out_seq", cap[7:0], 64'hFF);
        chk("t5_done_count", 64'(dcnt), 64'd1);

`ifdef JTAG_TX_PARITY_EN
        // Odd-parity bit follows the data bits.
        idle(2);
        ld(64'h07);
        cap = '0;
        for (int j = 0; j < 9; j++) begin sh(1'b0); cap = {cap[62:0], o_out[1]}; end
        chk("t6_seq_07", cap[8:0], 64'h00E);
        chk("t6_no_early_done", 64'(o_done[1]), 64'd0);
        sh(1'b0);
        chk("t6_done_07", 64'(o_done[1]), 64'd1);
        idle(2);
        ld(64'h03);
        for (int j = 0; j < 9; j++) sh(1'b0);
        chk("t6_parity_03", 64'(o_out[1]), 64'd1);
        sh(1'b0);
        chk("t6_done_03", 64'(o_done[1]), 64'd1);
`endif

        // Random traffic against the model; alternating load-heavy and long-run phases.
        idle(2);
        for (int c = 0; c < 4000; c++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_ld  = c[9] ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 7) == 0);
            r_se  = ($urandom_range(0, 3) != 0);
            r_ti  = 1'($urandom);
            r_d   = {$urandom, $urandom};
            cycle(r_rst, r_ld, r_d, r_se, r_ti);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
